// File: rtl/kb_code_decoder.sv
// rtl/kb_code_decoder.sv - PS/2 scan-code decoder: strips E0/F0 prefixes into make/break key events
// Optional suppression of typematic repeats via a single held-key record.
module kb_code_decoder #(
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       code_new,
  output logic       key_pressed,
  output logic [7:0] key_code,
  output logic       key_ext
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic          ev, ev_make, ev_ext, rec_match, emit;
  logic [7:0]    rec_code;
  logic          rec_ext, rec_valid;

  always_comb begin
    state_nxt = state;
    ev        = 1'b0;
    ev_make   = 1'b1;
    ev_ext    = 1'b0;
    if (rx_done_tick) begin
      case (state)
        IDLE: begin
          case (rx_data)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1: ;
            default: ev = 1'b1;
          endcase
        end
        EXT: begin
          case (rx_data)
            8'hF0: state_nxt = EXT_BRK;
            8'hE0: state_nxt = EXT;
            8'h12, 8'h59: state_nxt = IDLE;
            default: begin
              ev        = 1'b1;
              ev_ext    = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        BRK: begin
          case (rx_data)
            8'hF0: state_nxt = BRK;
            8'hE0: state_nxt = EXT_BRK;
            default: begin
              ev        = 1'b1;
              ev_make   = 1'b0;
              state_nxt = IDLE;
            end
          endcase
        end
        default: begin
          case (rx_data)
            8'hE0, 8'hF0: state_nxt = EXT_BRK;
            8'h12, 8'h59: state_nxt = IDLE;
            default: begin
              ev        = 1'b1;
              ev_make   = 1'b0;
              ev_ext    = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      // Abandoned prefix sequence: fall back silently.
      state_nxt = IDLE;
    end
  end

  assign rec_match = rec_valid && (rec_code == rx_data) && (rec_ext == ev_ext);
  assign emit      = ev && !(ev_make && SUPPRESS_REPEAT && rec_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      code_new    <= 1'b0;
      key_pressed <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      rec_code    <= 8'h00;
      rec_ext     <= 1'b0;
      rec_valid   <= 1'b0;
    end else begin
      state    <= state_nxt;
      code_new <= emit;
      if (rx_done_tick || state_nxt == IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + CW'(1);
      if (emit) begin
        key_code    <= rx_data;
        key_pressed <= ev_make;
        key_ext     <= ev_ext;
      end
      if (ev && ev_make) begin
        rec_code  <= rx_data;
        rec_ext   <= ev_ext;
        rec_valid <= 1'b1;
      end else if (ev && rec_match) begin
        rec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kb_code_decoder.sv
// tb/tb_kb_code_decoder.sv - scoreboard bench for kb_code_decoder, repeat-suppressing and plain instances
module tb_kb_code_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       cn_s, kp_s, ke_s, cn_n, kp_n, ke_n;
  logic [7:0] kc_s, kc_n;

  typedef struct {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
    int         cyc;
  } ev_t;

  ev_t q_s[$];
  ev_t q_n[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  kb_code_decoder #(.TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .code_new(cn_s), .key_pressed(kp_s), .key_code(kc_s), .key_ext(ke_s)
  );

  kb_code_decoder #(.TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .code_new(cn_n), .key_pressed(kp_n), .key_code(kc_n), .key_ext(ke_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_pop(input int which, input logic kp, input logic [7:0] kc, input logic ke);
    ev_t e;
    string nm;
    logic empty;
    nm = (which == 0) ? "sup" : "nosup";
    empty = (which == 0) ? (q_s.size() == 0) : (q_n.size() == 0);
    n_chk++;
    if (empty) begin
      n_fail++;
      $display("FAIL %s unexpected_event: got code=%h pressed=%b ext=%b cyc=%0d, required no event",
               nm, kc, kp, ke, cyc);
    end else begin
      e = (which == 0) ? q_s.pop_front() : q_n.pop_front();
      if (kc !== e.code || kp !== e.pressed || ke !== e.ext || cyc != e.cyc) begin
        n_fail++;
        $display("FAIL %s event: got code=%h pressed=%b ext=%b cyc=%0d, required code=%h pressed=%b ext=%b cyc=%0d",
                 nm, kc, kp, ke, cyc, e.code, e.pressed, e.ext, e.cyc);
      end
    end
  endtask

  // Monitor: every code_new pulse is matched against the head of its queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (cn_s) check_pop(0, kp_s, kc_s, ke_s);
      if (cn_n) check_pop(1, kp_n, kc_n, ke_n);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_done_tick = 1'b0;
      rx_data      = 8'($urandom);
    end
  endtask

  function automatic ev_t mk(input logic [7:0] code, input logic pressed, input logic ext);
    ev_t e;
    e.code = code; e.pressed = pressed; e.ext = ext; e.cyc = cyc + 1;
    return e;
  endfunction

  task automatic exp_b(input logic [7:0] code, input logic pressed, input logic ext);
    q_s.push_back(mk(code, pressed, ext));
    q_n.push_back(mk(code, pressed, ext));
  endtask

  task automatic exp_n(input logic [7:0] code, input logic pressed, input logic ext);
    q_n.push_back(mk(code, pressed, ext));
  endtask

  task automatic chk_rst(input string nm);
    n_chk++;
    if ({cn_s, kp_s, kc_s, ke_s} !== 11'h0) begin
      n_fail++;
      $display("FAIL %s sup: got new=%b pressed=%b code=%h ext=%b, required all zero", nm, cn_s, kp_s, kc_s, ke_s);
    end
    n_chk++;
    if ({cn_n, kp_n, kc_n, ke_n} !== 11'h0) begin
      n_fail++;
      $display("FAIL %s nosup: got new=%b pressed=%b code=%h ext=%b, required all zero", nm, cn_n, kp_n, kc_n, ke_n);
    end
  endtask

  initial begin
    reset = 1'b0;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk_rst("reset_state");
    end
    @(negedge clk);
    reset = 1'b1;
    gap(2);

    // Plain make and break
    send(8'h1D); exp_b(8'h1D, 1'b1, 1'b0); gap(3);
    send(8'hF0); gap(1); send(8'h1D); exp_b(8'h1D, 1'b0, 1'b0); gap(3);

    // Extended make/break, fake shift ignored
    send(8'hE0); send(8'h75); exp_b(8'h75, 1'b1, 1'b1); gap(2);
    send(8'hE0); send(8'hF0); send(8'h75); exp_b(8'h75, 1'b0, 1'b1); gap(2);
    send(8'hE0); send(8'h12); gap(3);

    // Typematic repeats
    send(8'h1C); exp_b(8'h1C, 1'b1, 1'b0); gap(2);
    send(8'h1C); exp_n(8'h1C, 1'b1, 1'b0); gap(2);
    send(8'h1C); exp_n(8'h1C, 1'b1, 1'b0); gap(2);
    send(8'hF0); send(8'h1C); exp_b(8'h1C, 1'b0, 1'b0); gap(2);
    send(8'h1C); exp_b(8'h1C, 1'b1, 1'b0); gap(2);
    send(8'hF0); send(8'h1C); exp_b(8'h1C, 1'b0, 1'b0); gap(2);

    // Prefix timeout: 16-cycle gap expires, 14 and 15 do not
    send(8'hF0); gap(16); send(8'h23); exp_b(8'h23, 1'b1, 1'b0); gap(2);
    send(8'hF0); gap(14); send(8'h23); exp_b(8'h23, 1'b0, 1'b0); gap(2);
    send(8'hF0); gap(15); send(8'h23); exp_b(8'h23, 1'b0, 1'b0); gap(2);

    // Back-to-back strobes
    send(8'hF0); send(8'h1B); exp_b(8'h1B, 1'b0, 1'b0);
    send(8'hAA); send(8'h24); exp_b(8'h24, 1'b1, 1'b0); gap(3);

    // Reset mid-sequence discards the pending break
    send(8'hF0);
    @(negedge clk);
    rx_done_tick = 1'b0;
    reset = 1'b0;
    #1 chk_rst("reset_mid");
    repeat (3) begin
      @(negedge clk);
      chk_rst("reset_hold");
    end
    reset = 1'b1;
    send(8'h1B); exp_b(8'h1B, 1'b1, 1'b0); gap(5);

    n_chk++;
    if (q_s.size() != 0) begin
      n_fail++;
      $display("FAIL sup missing_events: got %0d pending, required 0", q_s.size());
    end
    n_chk++;
    if (q_n.size() != 0) begin
      n_fail++;
      $display("FAIL nosup missing_events: got %0d pending, required 0", q_n.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
